// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: ROM read port, decode handshake and redirect input.
// The fetch stage uses the master modport; the ROM/decoder side uses slave.
interface instr_fetch_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_data;
    logic [ADDR_W-1:0] instr_pc;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output rom_en, rom_addr, instr_valid, instr_data, instr_pc,
        input  rom_data, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  rom_en, rom_addr, instr_valid, instr_data, instr_pc,
        output rom_data, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, ROM read issue (1-cycle latency), prefetch FIFO
// and a valid/ready hand-off to decode. A redirect reloads the PC and drops all
// buffered and in-flight words.
// Optional build macro FETCH_PERF_CNT_EN adds fetch_cnt / discard_cnt counters.
module instr_fetch #(
    parameter int              ADDR_W   = 8,
    parameter int              DATA_W   = 32,
    parameter int              DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic rst,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_cnt,
    output logic [15:0] discard_cnt,
`endif
    instr_fetch_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_FULL} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_addr;
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              flush, pop, push, credit_ok, issue;

    // Handshake qualifiers and the read credit (this cycle's pop frees a slot).
    always_comb begin
        flush     = bus.redirect && (state != S_BOOT);
        pop       = bus.instr_valid && bus.instr_ready;
        push      = inflight && !flush;
        credit_ok = (int'(count) + int'(inflight) - int'(pop)) < DEPTH;
    end

    // Next-state and read-issue decision; redirect overrides everything but reset.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_next = state;
        issue      = 1'b0;
        case (state)
            S_BOOT:  state_next = S_FETCH;
            S_FETCH: begin
                if (credit_ok) issue = 1'b1;
                else           state_next = S_FULL;
            end
            S_FULL:  if (pop) state_next = S_FETCH;
            default: state_next = S_BOOT;
        endcase
        if (flush) begin
            issue      = 1'b0;
            state_next = S_FETCH;
        end
    end

    // State register, PC, in-flight tracking and FIFO pointers/occupancy.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking everywhere so all updates see pre-edge values.
        if (rst) begin
            state         <= S_BOOT;
            pc            <= RESET_PC;
            inflight      <= 1'b0;
            inflight_addr <= RESET_PC;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
        end else begin
            state <= state_next;
            if (flush) begin
                pc       <= bus.redirect_pc;
                inflight <= 1'b0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (issue) begin
                    pc            <= pc + ADDR_W'(1);
                    inflight_addr <= pc;
                end
                inflight <= issue;
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // FIFO storage: capture the returning ROM word with the address it came from.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; count alone decides what is visible.
        if (push) begin
            fifo_data[wr_ptr] <= bus.rom_data;
            fifo_pc[wr_ptr]   <= inflight_addr;
        end
    end

    assign bus.rom_en      = issue && !rst;
    assign bus.rom_addr    = pc;
    assign bus.instr_valid = (count != '0);
    assign bus.instr_data  = bus.instr_valid ? fifo_data[rd_ptr] : '0;
    assign bus.instr_pc    = bus.instr_valid ? fifo_pc[rd_ptr]   : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [16:0] discard_sum;

    // Words lost to a redirect: FIFO entries not popped this cycle plus the in-flight one.
    always_comb begin
        discard_sum = {1'b0, discard_cnt} + 17'(count) + 17'(inflight) - 17'(pop);
    end

    // Saturating performance counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt   <= '0;
            discard_cnt <= '0;
        end else begin
            if (pop && (fetch_cnt != 32'hFFFF_FFFF)) fetch_cnt <= fetch_cnt + 32'd1;
            if (flush) discard_cnt <= discard_sum[16] ? 16'hFFFF : discard_sum[15:0];
        end
    end
`endif
endmodule
